// File: rtl/sha_mmio_pkg.sv
// Shared register map indices, CTRL bit positions and FSM states for the
// SHA-256 bus-side controller.
package sha_mmio_pkg;

  localparam int unsigned IDX_W      = 15;
  localparam int unsigned IDX_CTRL   = 0;
  localparam int unsigned IDX_LEN    = 1;
  localparam int unsigned IDX_SRC    = 2;
  localparam int unsigned IDX_MSG    = 8;
  localparam int unsigned IDX_DIG    = 64;

  localparam int unsigned CTRL_START = 0;
  localparam int unsigned CTRL_CLEAR = 1;
  localparam int unsigned CTRL_IRQEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_e;

endpackage

// File: rtl/sha_pad_block.sv
// Forms the single padded SHA-256 block from the message buffer and word count.
module sha_pad_block
  import sha_mmio_pkg::*;
#(
  parameter int unsigned MSG_WORDS = 13,
  parameter int unsigned LEN_W     = 4
) (
  input  logic [31:0]      msg_i [MSG_WORDS],
  input  logic [LEN_W-1:0] len_i,
  output logic [511:0]     block_o
);

  // Message words MSB-first, then the 1 marker bit, then the 64-bit bit length.
  always_comb begin
    block_o = '0;
    for (int unsigned i = 0; i < MSG_WORDS; i++) begin
      if (LEN_W'(i) < len_i) block_o[511-32*i -: 32] = msg_i[i];
    end
    for (int unsigned i = 1; i <= MSG_WORDS; i++) begin
      if (LEN_W'(i) == len_i) block_o[511-32*i] = 1'b1;
    end
    block_o[63:0] = {32'b0, 32'(len_i) << 5};
  end

endmodule

// File: rtl/sha_mmio_ctrl.sv
// NIOS I/O-bus controller for the SHA-256 core: message buffer, block padding,
// start/done sequencing, digest readback and done interrupt.
module sha_mmio_ctrl
  import sha_mmio_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0300,
  parameter int unsigned MSG_WORDS   = 13,
  parameter int unsigned DIGEST_BITS = 256
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   io_en,
  input  logic                   rw,
  input  logic                   byte_select,
  input  logic [15:0]            address,
  input  logic [7:0]             datain_nios,
  output logic [7:0]             dataout,
  output logic                   dataout_en,
  input  logic [31:0]            datain_scan,
  input  logic                   scan_valid,
  output logic [511:0]           core_block,
  output logic                   core_start,
  output logic                   core_rst,
  input  logic                   core_done,
  input  logic [DIGEST_BITS-1:0] core_digest,
  output logic                   hashing,
  output logic                   irq
);

  localparam int unsigned LEN_W     = $clog2(MSG_WORDS + 1);
  localparam int unsigned WORD_W    = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
  localparam int unsigned DIG_BYTES = DIGEST_BITS / 8;
  localparam int unsigned DK_W      = $clog2(DIG_BYTES);
  localparam int unsigned MSG_END   = IDX_MSG + 4 * MSG_WORDS;
  localparam int unsigned DIG_END   = IDX_DIG + DIG_BYTES;

  state_e                 state_q;
  logic                   done_q, irq_en_q, src_q;
  logic [LEN_W-1:0]       len_q, ptr_q;
  logic [31:0]            msg_q [MSG_WORDS];
  logic [DIGEST_BITS-1:0] digest_q;
  logic [7:0]             dataout_q;
  logic                   dataout_en_q, core_start_q, core_rst_q;
  logic                   wr_seen_q;
  logic [15:0]            wr_addr_q;

  logic [IDX_W-1:0]  idx;
  logic              is_reg, is_msg, is_dig, acc, wr_act, commit, rd_acc;
  logic              ctrl_wr, busy;
  logic [WORD_W-1:0] msg_word;
  logic [1:0]        msg_byte;
  logic [DK_W-1:0]   dig_k;
  logic [7:0]        rdata;

  function automatic logic [LEN_W-1:0] sat_len(input logic [7:0] v);
    if (v == 8'd0)                return LEN_W'(1);
    else if (v > 8'(MSG_WORDS))   return LEN_W'(MSG_WORDS);
    else                          return LEN_W'(v);
  endfunction

  // Address decode; a write commits only on the first cycle of its access.
  assign idx      = IDX_W'((address - BASE_ADDR) >> 1);
  assign is_reg   = idx <= IDX_W'(IDX_SRC);
  assign is_msg   = (idx >= IDX_W'(IDX_MSG)) && (idx < IDX_W'(MSG_END));
  assign is_dig   = (idx >= IDX_W'(IDX_DIG)) && (idx < IDX_W'(DIG_END));
  assign acc      = io_en & ~byte_select & (is_reg | is_msg | is_dig);
  assign wr_act   = io_en & ~byte_select & ~rw;
  assign commit   = acc & ~rw & ~(wr_seen_q && (wr_addr_q == address));
  assign rd_acc   = acc & rw;
  assign ctrl_wr  = commit && (idx == IDX_W'(IDX_CTRL));
  assign busy     = state_q != ST_IDLE;
  assign msg_word = WORD_W'((idx - IDX_W'(IDX_MSG)) >> 2);
  assign msg_byte = 2'(idx - IDX_W'(IDX_MSG));
  assign dig_k    = DK_W'(idx - IDX_W'(IDX_DIG));

  always_comb begin
    rdata = 8'h00;
    if (is_msg) begin
      rdata = msg_q[msg_word][{~msg_byte, 3'b000} +: 8];
    end else if (is_dig) begin
      rdata = digest_q[{dig_k, 3'b000} +: 8];
    end else begin
      case (idx)
        IDX_W'(IDX_CTRL): rdata = {5'b0, irq_en_q, busy, done_q};
        IDX_W'(IDX_LEN):  rdata = 8'(len_q);
        IDX_W'(IDX_SRC):  rdata = {7'b0, src_q};
        default:          rdata = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      done_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      src_q        <= 1'b0;
      len_q        <= LEN_W'(1);
      ptr_q        <= '0;
      digest_q     <= '0;
      for (int unsigned i = 0; i < MSG_WORDS; i++) msg_q[i] <= '0;
      dataout_q    <= 8'h00;
      dataout_en_q <= 1'b0;
      core_start_q <= 1'b0;
      core_rst_q   <= 1'b0;
      wr_seen_q    <= 1'b0;
      wr_addr_q    <= '0;
    end else begin
      core_start_q <= 1'b0;
      core_rst_q   <= 1'b0;
      wr_seen_q    <= wr_act;
      wr_addr_q    <= address;
      dataout_q    <= rd_acc ? rdata : 8'h00;
      dataout_en_q <= rd_acc;

      // Configuration and buffer are frozen while a hash is in flight.
      if (commit && !busy) begin
        if (idx == IDX_W'(IDX_LEN)) len_q <= sat_len(datain_nios);
        if (idx == IDX_W'(IDX_SRC)) src_q <= datain_nios[0];
        if (is_msg) msg_q[msg_word][{~msg_byte, 3'b000} +: 8] <= datain_nios;
      end
      if (ctrl_wr) irq_en_q <= datain_nios[CTRL_IRQEN];

      case (state_q)
        ST_IDLE: begin
          if (ctrl_wr && datain_nios[CTRL_START] && !datain_nios[CTRL_CLEAR]) begin
            done_q <= 1'b0;
            if (src_q) begin
              state_q <= ST_SCAN;
              ptr_q   <= '0;
            end else begin
              state_q      <= ST_REQ;
              core_start_q <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (scan_valid) begin
            msg_q[WORD_W'(ptr_q)] <= datain_scan;
            ptr_q                 <= ptr_q + 1'b1;
            if (ptr_q == len_q - 1'b1) begin
              state_q      <= ST_REQ;
              core_start_q <= 1'b1;
            end
          end
        end
        ST_REQ:  state_q <= ST_WAIT;
        ST_WAIT: begin
          if (core_done) begin
            digest_q <= core_digest;
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase

      // Clear overrides everything above, including a same-cycle start.
      if (ctrl_wr && datain_nios[CTRL_CLEAR]) begin
        state_q      <= ST_IDLE;
        done_q       <= 1'b0;
        ptr_q        <= '0;
        core_start_q <= 1'b0;
        core_rst_q   <= 1'b1;
      end
    end
  end

  sha_pad_block #(
    .MSG_WORDS (MSG_WORDS),
    .LEN_W     (LEN_W)
  ) u_pad (
    .msg_i   (msg_q),
    .len_i   (len_q),
    .block_o (core_block)
  );

  assign dataout    = dataout_q;
  assign dataout_en = dataout_en_q;
  assign core_start = core_start_q;
  assign core_rst   = core_rst_q;
  assign hashing    = (state_q == ST_SCAN) || (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign irq        = done_q & irq_en_q;

endmodule

// File: tb/tb_sha_mmio_ctrl.sv
// Directed bench for sha_mmio_ctrl: bus and scanner hashing, busy lockout,
// clear, interrupt and held-write single-commit behaviour.
module tb_sha_mmio_ctrl;

  localparam logic [15:0] BASE = 16'h0300;

  logic         clk = 1'b0;
  logic         reset, io_en, rw, byte_select, scan_valid, core_done;
  logic [15:0]  address;
  logic [7:0]   datain_nios, dataout;
  logic         dataout_en, core_start, core_rst, hashing, irq;
  logic [31:0]  datain_scan;
  logic [511:0] core_block;
  logic [255:0] core_digest;

  int n_cmp = 0;
  int n_err = 0;
  int start_cnt = 0;
  int rst_cnt = 0;
  int s0, r0;

  localparam logic [255:0] D1 = {32'hA1B2C3D4, 192'h0, 32'h89ABCDEF};
  localparam logic [255:0] D2 = 256'h5A3C;

  sha_mmio_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .io_en       (io_en),
    .rw          (rw),
    .byte_select (byte_select),
    .address     (address),
    .datain_nios (datain_nios),
    .dataout     (dataout),
    .dataout_en  (dataout_en),
    .datain_scan (datain_scan),
    .scan_valid  (scan_valid),
    .core_block  (core_block),
    .core_start  (core_start),
    .core_rst    (core_rst),
    .core_done   (core_done),
    .core_digest (core_digest),
    .hashing     (hashing),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (core_start) start_cnt++;
    if (core_rst)   rst_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input int idx, input logic [7:0] d);
    io_en = 1'b1; rw = 1'b0; address = 16'(BASE + 16'(2 * idx)); datain_nios = d;
    tick();
    io_en = 1'b0;
    tick();
  endtask

  task automatic held_wr(input int idx, input logic [7:0] d, input int cycles);
    io_en = 1'b1; rw = 1'b0; address = 16'(BASE + 16'(2 * idx)); datain_nios = d;
    repeat (cycles) tick();
    io_en = 1'b0;
    tick();
  endtask

  // Compares {dataout_en, dataout} one cycle after a single-cycle read.
  task automatic chk_rd(input string tag, input int idx, input logic en_exp, input logic [7:0] exp);
    logic [7:0] d;
    logic       en;
    io_en = 1'b1; rw = 1'b1; address = 16'(BASE + 16'(2 * idx));
    tick();
    d = dataout; en = dataout_en;
    io_en = 1'b0; rw = 1'b0;
    tick();
    chk(tag, {55'b0, en, d}, {55'b0, en_exp, exp});
  endtask

  task automatic scan(input logic [31:0] w);
    datain_scan = w; scan_valid = 1'b1;
    tick();
    scan_valid = 1'b0;
    tick();
    tick();
  endtask

  task automatic finish_core(input logic [255:0] dg);
    repeat (64) tick();
    core_digest = dg; core_done = 1'b1;
    tick();
    core_done = 1'b0;
    tick();
  endtask

  initial begin
    reset = 1'b1; io_en = 1'b0; rw = 1'b0; byte_select = 1'b0; address = '0;
    datain_nios = '0; datain_scan = '0; scan_valid = 1'b0; core_done = 1'b0;
    core_digest = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk("rst_core_start", 64'(core_start), 64'd0);
    chk("rst_core_rst",   64'(core_rst), 64'd0);
    chk("rst_dout",       {55'b0, dataout_en, dataout}, 64'd0);
    chk("rst_hashing",    64'(hashing), 64'd0);
    chk_rd("rst_stat", 0, 1'b1, 8'h00);
    chk_rd("rst_len",  1, 1'b1, 8'h01);
    chk_rd("unmapped_idx3", 3, 1'b0, 8'h00);
    chk("rst_no_start", 64'(start_cnt), 64'd0);

    // Bus mode single word
    wr(1, 8'h01);
    wr(8, 8'h61); wr(9, 8'h62); wr(10, 8'h63); wr(11, 8'h00);
    chk_rd("msg_rd_b1", 9, 1'b1, 8'h62);
    chk("blk_w0",   64'(core_block[511:480]), 64'h61626300);
    chk("blk_pad",  64'(core_block[479:448]), 64'h80000000);
    chk("blk_len",  core_block[63:0], 64'd32);
    chk("blk_zero", 64'(core_block[447:64] == '0), 64'd1);
    s0 = start_cnt;
    wr(0, 8'h01);
    chk("bus_start_once", 64'(start_cnt - s0), 64'd1);
    chk("bus_hashing", 64'(hashing), 64'd1);
    finish_core(D1);
    chk("bus_start_still_once", 64'(start_cnt - s0), 64'd1);
    chk_rd("bus_stat_done", 0, 1'b1, 8'h01);
    chk_rd("bus_dig_b0",  64, 1'b1, 8'hEF);
    chk_rd("bus_dig_b31", 95, 1'b1, 8'hA1);
    chk_rd("unmapped_idx96", 96, 1'b0, 8'h00);

    // LEN saturation and scanner mode
    wr(1, 8'h00);
    chk_rd("len_zero_sat", 1, 1'b1, 8'h01);
    wr(1, 8'd20);
    chk_rd("len_max_sat", 1, 1'b1, 8'h0D);
    wr(2, 8'h01); wr(1, 8'h03);
    chk_rd("src_rd", 2, 1'b1, 8'h01);
    s0 = start_cnt;
    wr(0, 8'h01);
    chk_rd("scan_stat_busy", 0, 1'b1, 8'h02);
    chk("scan_hashing", 64'(hashing), 64'd1);
    scan(32'hA);
    scan(32'hB);
    chk("scan_no_req_early", 64'(start_cnt - s0), 64'd0);
    scan(32'hC);
    chk("scan_req_after3", 64'(start_cnt - s0), 64'd1);
    chk("scan_w0", 64'(core_block[511:480]), 64'hA);
    chk("scan_w1", 64'(core_block[479:448]), 64'hB);
    chk("scan_w2", 64'(core_block[447:416]), 64'hC);
    chk("scan_pad", 64'(core_block[415:384]), 64'h80000000);
    chk("scan_len", core_block[63:0], 64'd96);
    finish_core(D2);
    chk_rd("scan_stat_done", 0, 1'b1, 8'h01);
    chk_rd("scan_dig_b0", 64, 1'b1, 8'h3C);

    // Writes and start ignored while waiting on the core
    wr(2, 8'h00); wr(1, 8'h01);
    s0 = start_cnt;
    wr(0, 8'h01);
    chk("wait_start_once", 64'(start_cnt - s0), 64'd1);
    wr(8, 8'hFF);
    wr(0, 8'h01);
    wr(1, 8'h05);
    chk_rd("wait_msg_kept", 8, 1'b1, 8'h00);
    chk_rd("wait_stat_busy", 0, 1'b1, 8'h02);
    chk_rd("wait_len_kept", 1, 1'b1, 8'h01);
    chk_rd("wait_old_digest", 64, 1'b1, 8'h3C);
    chk("wait_blk_w0", 64'(core_block[511:480]), 64'hA);
    chk("wait_no_second_start", 64'(start_cnt - s0), 64'd1);
    finish_core(D1);
    chk_rd("wait_dig_b0", 64, 1'b1, 8'hEF);

    // Clear during SCAN
    wr(2, 8'h01); wr(1, 8'h02);
    s0 = start_cnt;
    wr(0, 8'h01);
    scan(32'h11111111);
    chk("clr_no_start", 64'(start_cnt - s0), 64'd0);
    r0 = rst_cnt;
    wr(0, 8'h02);
    chk("clr_rst_once", 64'(rst_cnt - r0), 64'd1);
    chk("clr_hashing", 64'(hashing), 64'd0);
    chk_rd("clr_stat", 0, 1'b1, 8'h00);
    scan(32'h22222222);
    chk("clr_scan_ign_w0", 64'(core_block[511:480]), 64'h11111111);
    chk("clr_scan_ign_w1", 64'(core_block[479:448]), 64'hB);
    chk("clr_scan_no_start", 64'(start_cnt - s0), 64'd0);
    r0 = rst_cnt;
    wr(0, 8'h03);
    chk("clrstart_rst", 64'(rst_cnt - r0), 64'd1);
    chk("clrstart_no_start", 64'(start_cnt - s0), 64'd0);
    chk_rd("clrstart_stat", 0, 1'b1, 8'h00);

    // Interrupt and held writes
    wr(0, 8'h04);
    chk_rd("irqen_stat", 0, 1'b1, 8'h04);
    wr(2, 8'h00);
    s0 = start_cnt;
    held_wr(0, 8'h05, 5);
    chk("held_start_once", 64'(start_cnt - s0), 64'd1);
    chk("irq_low_busy", 64'(irq), 64'd0);
    finish_core(D2);
    chk("irq_set", 64'(irq), 64'd1);
    chk_rd("irq_stat", 0, 1'b1, 8'h05);
    r0 = rst_cnt;
    held_wr(0, 8'h06, 5);
    chk("held_clear_once", 64'(rst_cnt - r0), 64'd1);
    chk("irq_cleared", 64'(irq), 64'd0);
    chk_rd("irq_stat_after_clr", 0, 1'b1, 8'h04);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
